hack_data_memory: RTL and testbench
===================================

// Module: hack_data_memory
// PURPOSE
//  Responder end of the CPU data-memory bus: decodes address/load from the CPU and returns the M word.
//  Implements the Hack data memory map: RAM 0x0000-0x3FFF, screen 0x4000-0x5FFF, keyboard 0x6000.
//  Keyboard word is loaded through a valid/ready handshake from the keyboard front end.
//  Screen writes are mirrored into an update FIFO streamed to the display controller.
// PARAMETERS
//  FIFO_DEPTH  8       screen-update FIFO entries; power of two, >= 2
//  KBD_ADDR    24576   keyboard register address (0x6000)
// PORTS
//  clock           in   1   system clock; all state updates on rising edge
//  reset           in   1   asynchronous, active-high reset
//  address         in   15  CPU addressM
//  in              in   16  CPU outM, write data
//  load            in   1   CPU writeM, write enable
//  out             out  16  M word to CPU inM; combinational from address
//  kbd_valid       in   1   key-press code offered
//  kbd_code        in   16  key-press code
//  kbd_ready       out  1   keyboard register accepts a code
//  kbd_release     in   1   1-cycle pulse: key released
//  scr_upd_valid   out  1   FIFO head holds a screen update
//  scr_upd_addr    out  13  screen word offset (address - 0x4000)
//  scr_upd_data    out  16  screen word value
//  scr_upd_ready   in   1   display controller pops the head
//  scr_overflow    out  1   sticky: a screen update was dropped
// BEHAVIOUR
//  Reset: kbd reg=0, kbd_ready=1, FIFO empty, scr_upd_valid=0, scr_overflow=0. RAM/screen arrays not cleared.
//  Reset mid-operation: pending FIFO entries discarded; held key cleared.
//  Read: out = RAM[a] (a<0x4000), SCREEN[a-0x4000] (0x4000..0x5FFF), key (a==KBD_ADDR), else 0. Zero latency.
//  Write: at rising edge when load=1: RAM/screen word updated; out reflects it from the next cycle.
//  Writes to KBD_ADDR or a>0x6000 ignored (no state change).
//  Screen write also pushes {a-0x4000, in} into FIFO at the same edge; scr_upd_valid high from next cycle.
//  FIFO pop when scr_upd_valid & scr_upd_ready. No bypass: push into empty FIFO never visible same cycle.
//  Full + push + pop same edge: both happen, count unchanged. Full + push, no pop: screen array still
//   written, update dropped, scr_overflow set; sticky until reset.
//  FIFO order strictly preserved; data outputs hold head value while valid & !ready.
//  Keyboard FSM: IDLE (key=0) / HELD (key=code). kbd_ready=1 in both states.
//   kbd_valid -> key=kbd_code, state HELD (a new code in HELD overwrites).
//   kbd_release -> key=0, state IDLE. valid & release same edge: new code wins (HELD).
//   kbd_valid with kbd_code==0 -> IDLE, key=0.
//  Width rules: screen offset = address[12:0] when address[14:13]==2'b10; no arithmetic beyond decode.
// STRUCTURE
//  Shared package hack_mem_pkg: RAM_BASE, SCR_BASE, SCR_WORDS, KBD_ADDR constants; kbd state enum.
//  Sub-module sync_fifo (parameterised width/depth, count-based full/empty) for screen updates.
//  RAM 16K x16 and screen 8K x16: async read, sync write arrays inside this module.
// TESTING
//  After reset: read 0x6000 -> out=0; kbd_ready=1; scr_upd_valid=0; scr_overflow=0.
//  Write 0x1234 to 0x0005, read next cycle -> out=0x1234; scr_upd_valid stays 0.
//  Write 0xFFFF to 0x4001, ready=0 -> next cycle valid=1, addr=0x0001, data=0xFFFF, held; out(0x4001)=0xFFFF.
//  ready=0, 9 screen writes 0x4000..0x4008 (DEPTH 8) -> overflow=1; pops return offsets 0..7 in order;
//   SCREEN[8] still written.
//  kbd_valid, code 0x0041 -> out(0x6000)=0x0041; valid 0x0042 + release same edge -> 0x0042; release -> 0.
//  Write 0x5555 to 0x6000 and 0x7000 -> out(0x6000) unchanged, out(0x7000)=0; reset with 3 queued -> valid=0.

Source files
------------

// File: rtl/hack_mem_pkg.sv
// Shared constants and types for the Hack data-memory responder:
// memory-map bases, array sizes, keyboard FSM states and the screen-update record.
package hack_mem_pkg;

  localparam logic [14:0] RAM_BASE  = 15'h0000;
  localparam logic [14:0] SCR_BASE  = 15'h4000;
  localparam logic [14:0] KBD_ADDR  = 15'h6000;
  localparam int          RAM_WORDS = 16384;
  localparam int          SCR_WORDS = 8192;

  typedef enum logic {
    KBD_IDLE = 1'b0,
    KBD_HELD = 1'b1
  } kbd_state_e;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } scr_upd_t;

endpackage

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO; head word is always visible on head_data.
// A push while full is accepted only if a pop frees a slot at the same edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign push_ok   = push && (!full || pop);
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage arrays carry no reset; the pointers/count alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/hack_data_memory.sv
// Hack data memory responder: RAM, memory-mapped screen and keyboard register,
// with screen writes mirrored into an update FIFO for the display controller.
module hack_data_memory
  import hack_mem_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [14:0] KBD_ADDR   = hack_mem_pkg::KBD_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] address,
  input  logic [15:0] in,
  input  logic        load,
  output logic [15:0] out,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_code,
  output logic        kbd_ready,
  input  logic        kbd_release,
  output logic        scr_upd_valid,
  output logic [12:0] scr_upd_addr,
  output logic [15:0] scr_upd_data,
  input  logic        scr_upd_ready,
  output logic        scr_overflow
);

  logic [15:0] ram_mem [RAM_WORDS];
  logic [15:0] scr_mem [SCR_WORDS];

  logic        is_ram, is_scr, is_kbd;
  logic        scr_push, scr_pop, fifo_empty, fifo_full;
  scr_upd_t    push_rec, head_rec;

  kbd_state_e  kbd_state_q, kbd_state_d;
  logic [15:0] key_q, key_d;
  logic        overflow_q, overflow_d;

  assign is_ram = (address[14] == RAM_BASE[14]);
  assign is_scr = (address[14:13] == SCR_BASE[14:13]);
  assign is_kbd = (address == KBD_ADDR);

  always_comb begin
    out = '0;
    if (is_ram)      out = ram_mem[address[13:0]];
    else if (is_scr) out = scr_mem[address[12:0]];
    else if (is_kbd) out = (kbd_state_q == KBD_HELD) ? key_q : '0;
  end

  always_ff @(posedge clock) begin
    if (load && is_ram) ram_mem[address[13:0]] <= in;
    if (load && is_scr) scr_mem[address[12:0]] <= in;
  end

  // A code of zero is treated as "no key", and a fresh code beats a release.
  always_comb begin
    kbd_state_d = kbd_state_q;
    key_d       = key_q;
    if (kbd_valid) begin
      kbd_state_d = (kbd_code == '0) ? KBD_IDLE : KBD_HELD;
      key_d       = kbd_code;
    end else if (kbd_release) begin
      kbd_state_d = KBD_IDLE;
      key_d       = '0;
    end
  end

  assign kbd_ready = 1'b1;

  assign scr_push      = load && is_scr;
  assign scr_pop       = scr_upd_valid && scr_upd_ready;
  assign push_rec      = '{addr: address[12:0], data: in};
  assign scr_upd_valid = !fifo_empty;
  assign scr_upd_addr  = head_rec.addr;
  assign scr_upd_data  = head_rec.data;
  assign scr_overflow  = overflow_q;
  assign overflow_d    = overflow_q || (scr_push && fifo_full && !scr_pop);

  sync_fifo #(
    .WIDTH ($bits(scr_upd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_scr_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (scr_push),
    .push_data (push_rec),
    .pop       (scr_pop),
    .head_data (head_rec),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kbd_state_q <= KBD_IDLE;
      key_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      kbd_state_q <= kbd_state_d;
      key_q       <= key_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed bench for hack_data_memory: screen updates go through a scoreboard queue
// checked by an independent monitor; memory/keyboard reads are checked inline.
module tb_hack_data_memory;
  import hack_mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [14:0] address;
  logic [15:0] in;
  logic        load;
  logic [15:0] out;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        kbd_ready;
  logic        kbd_release;
  logic        scr_upd_valid;
  logic [12:0] scr_upd_addr;
  logic [15:0] scr_upd_data;
  logic        scr_upd_ready;
  logic        scr_overflow;

  int n_pass  = 0;
  int n_total = 0;
  scr_upd_t exp_q[$];

  hack_data_memory #(.FIFO_DEPTH(8), .KBD_ADDR(15'h6000)) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .in            (in),
    .load          (load),
    .out           (out),
    .kbd_valid     (kbd_valid),
    .kbd_code      (kbd_code),
    .kbd_ready     (kbd_ready),
    .kbd_release   (kbd_release),
    .scr_upd_valid (scr_upd_valid),
    .scr_upd_addr  (scr_upd_addr),
    .scr_upd_data  (scr_upd_data),
    .scr_upd_ready (scr_upd_ready),
    .scr_overflow  (scr_overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic rd(input string name, input logic [14:0] a, input logic [15:0] exp);
    address = a;
    #1;
    check(name, out, exp);
  endtask

  task automatic expect_upd(input logic [12:0] a, input logic [15:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic drain();
    scr_upd_ready = 1'b1;
    for (int i = 0; i < 40 && scr_upd_valid; i++) tick();
    check("drain_done_valid", scr_upd_valid, 0);
    check("drain_sb_empty", exp_q.size(), 0);
  endtask

  // Monitor: every accepted pop must match the oldest expected update.
  always @(negedge clock) begin
    if (!reset && scr_upd_valid && scr_upd_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop_addr", scr_upd_addr, 32'hFFFF_FFFF);
      end else begin
        scr_upd_t e;
        e = exp_q.pop_front();
        check("pop_addr", scr_upd_addr, e.addr);
        check("pop_data", scr_upd_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    address       = 15'h6000;
    in            = '0;
    load          = 1'b0;
    kbd_valid     = 1'b0;
    kbd_code      = '0;
    kbd_release   = 1'b0;
    scr_upd_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    rd("rst_kbd_out", 15'h6000, 16'h0000);
    check("rst_kbd_ready", kbd_ready, 1);
    check("rst_valid", scr_upd_valid, 0);
    check("rst_overflow", scr_overflow, 0);

    // RAM write/read, no screen update
    wr(15'h0005, 16'h1234);
    rd("ram_0005", 15'h0005, 16'h1234);
    check("ram_no_upd", scr_upd_valid, 0);

    // Single screen write held while not ready
    expect_upd(13'h0001, 16'hFFFF);
    wr(15'h4001, 16'hFFFF);
    check("scr1_valid", scr_upd_valid, 1);
    check("scr1_addr", scr_upd_addr, 13'h0001);
    check("scr1_data", scr_upd_data, 16'hFFFF);
    tick(); tick();
    check("scr1_hold_addr", scr_upd_addr, 13'h0001);
    check("scr1_hold_data", scr_upd_data, 16'hFFFF);
    rd("scr_4001", 15'h4001, 16'hFFFF);
    drain();

    // Overflow: nine writes into an eight-entry FIFO, last one dropped
    scr_upd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_upd(13'(i), 16'hA000 + 16'(i));
      wr(15'h4000 + 15'(i), 16'hA000 + 16'(i));
    end
    check("ovf_set", scr_overflow, 1);
    check("ovf_valid", scr_upd_valid, 1);
    rd("scr_4008_written", 15'h4008, 16'hA008);

    // Full + push + pop at one edge: both happen
    scr_upd_ready = 1'b1;
    expect_upd(13'h0010, 16'hBEEF);
    wr(15'h4010, 16'hBEEF);
    drain();
    check("ovf_sticky", scr_overflow, 1);

    // Keyboard handshake
    kbd_valid = 1'b1; kbd_code = 16'h0041;
    tick();
    kbd_valid = 1'b0;
    rd("kbd_41", 15'h6000, 16'h0041);
    kbd_valid = 1'b1; kbd_code = 16'h0042; kbd_release = 1'b1;
    tick();
    kbd_valid = 1'b0; kbd_release = 1'b0;
    rd("kbd_42_wins", 15'h6000, 16'h0042);
    kbd_release = 1'b1;
    tick();
    kbd_release = 1'b0;
    rd("kbd_released", 15'h6000, 16'h0000);
    kbd_valid = 1'b1; kbd_code = 16'h0043;
    tick();
    kbd_code = 16'h0000;
    tick();
    kbd_valid = 1'b0;
    rd("kbd_zero_code", 15'h6000, 16'h0000);

    // Ignored writes must not alias into RAM or screen
    kbd_valid = 1'b1; kbd_code = 16'h0043;
    tick();
    kbd_valid = 1'b0;
    wr(15'h3000, 16'h1111);
    expect_upd(13'h1000, 16'h0F0F);
    wr(15'h5000, 16'h0F0F);
    wr(15'h6000, 16'h5555);
    rd("kbd_write_ignored", 15'h6000, 16'h0043);
    wr(15'h7000, 16'h5555);
    rd("unmapped_read", 15'h7000, 16'h0000);
    rd("ram_3000_intact", 15'h3000, 16'h1111);
    rd("scr_5000_intact", 15'h5000, 16'h0F0F);
    drain();

    // Reset with three queued updates discards them and clears the key
    scr_upd_ready = 1'b0;
    wr(15'h4020, 16'h0001);
    wr(15'h4021, 16'h0002);
    wr(15'h4022, 16'h0003);
    check("pre_rst_valid", scr_upd_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("in_rst_valid", scr_upd_valid, 0);
    tick();
    reset = 1'b0;
    scr_upd_ready = 1'b1;
    tick();
    check("post_rst_valid", scr_upd_valid, 0);
    check("post_rst_overflow", scr_overflow, 0);
    rd("post_rst_key", 15'h6000, 16'h0000);
    check("post_rst_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
